// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. A single full-adder cell is iterated LSB-first
//   over WIDTH cycles. An accepted start loads the operands. After WIDTH RUN
//   cycles the result registers update and done pulses for one cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only while idle
//   a, b   in   WIDTH  operands, captured on an accepted start
//   cin    in   1      carry-in for add (ignored when sub=1)
//   sub    in   1      0: a+b+cin, 1: a-b (a+~b+1)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, results just updated
//   sum    out  WIDTH  result, held until the next completion
//   cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // r_a_sh doubles as the result shift register: each step consumes bit 0
    // and the new sum bit enters at the MSB, so after WIDTH steps it holds
    // the full result.
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] w_a_nxt;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic             w_s;
    logic             w_c_nxt;
    logic             w_last;
    logic             w_accept;

    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_nxt  = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = (r_state == S_IDLE) && start;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_a_nxt = w_s;
        end else begin : g_wn
            assign w_a_nxt = {w_s, r_a_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= sub ? ~b : b;
                r_c    <= sub ? 1'b1 : cin;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh <= w_a_nxt;
                r_b_sh <= r_b_sh >> 1;
                r_c    <= w_c_nxt;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    // On the last step r_c is the carry into the MSB.
                    r_sum  <= w_a_nxt;
                    r_cout <= w_c_nxt;
                    r_ovf  <= r_c ^ w_c_nxt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8, 4 and 1. Expected
//   results come from an arithmetic model. They are queued when an operation
//   is accepted and are popped and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       st8 = 1'b0, st4 = 1'b0, st1 = 1'b0;

    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a[0:0]), .b(b[0:0]), .cin(cin), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    // {ovf, cout, sum[7:0]}
    typedef logic [9:0] res_t;

    res_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    res_t last_exp = '0;

    function automatic res_t model(int w, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
        logic [8:0] m, aa, bb, full;
        logic       co, ov;
        m    = 9'((1 << w) - 1);
        aa   = {1'b0, av} & m;
        bb   = sb ? (~{1'b0, bv} & m) : ({1'b0, bv} & m);
        full = aa + bb + {8'd0, (sb ? 1'b1 : ci)};
        co   = full[w];
        // Signed overflow: same-sign operands giving a result of the other sign.
        ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        full = full & m;
        return {ov, co, full[7:0]};
    endfunction

    function automatic res_t obs(int w);
        case (w)
            8:       return {ovf8, cout8, sum8};
            4:       return {ovf4, cout4, 4'd0, sum4};
            default: return {ovf1, cout1, 7'd0, sum1};
        endcase
    endfunction

    function automatic logic done_of(int w);
        case (w)
            8:       return done8;
            4:       return done4;
            default: return done1;
        endcase
    endfunction

    task automatic set_start(int w, logic v);
        case (w)
            8:       st8 = v;
            4:       st4 = v;
            default: st1 = v;
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One operation: accept, wait for done (bounded), compare result,
    // check latency and single-cycle done pulse.
    task automatic run_op(int w, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
        int   cyc;
        res_t e;
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        q.push_back(model(w, av, bv, ci, sb));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_of(w) && cyc < w + 6);
        chk($sformatf("w%0d latency", w), 32'(cyc), 32'(w + 1));
        if (done_of(w)) begin
            e = q.pop_front();
            chk($sformatf("w%0d res a=%h b=%h ci=%b sub=%b", w, av, bv, ci, sb),
                32'(obs(w)), 32'(e));
            last_exp = e;
        end else begin
            void'(q.pop_front());
            chk($sformatf("w%0d done_timeout", w), 32'(done_of(w)), 32'd1);
        end
        @(negedge clk);
        chk($sformatf("w%0d done_pulse", w), 32'(done_of(w)), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t       e;
        logic [7:0] va[3];
        logic [7:0] vb[3];
        va = '{8'h11, 8'hC3, 8'h7E};
        vb = '{8'h22, 8'h5A, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out8", 32'(obs(8)), 32'd0);
        chk("rst_ctl8", 32'({busy8, done8}), 32'd0);
        chk("rst_out4", 32'(obs(4)), 32'd0);
        chk("rst_ctl4", 32'({busy4, done4}), 32'd0);
        chk("rst_out1", 32'(obs(1)), 32'd0);
        chk("rst_ctl1", 32'({busy1, done1}), 32'd0);
        rst = 1'b0;

        // Directed add / subtract cases
        run_op(8, 8'h00, 8'h00, 1'b0, 1'b0);  // 00, c0, v0
        run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0);  // 00, c1, v0
        run_op(8, 8'h7F, 8'h00, 1'b1, 1'b0);  // 80, c0, v1
        run_op(8, 8'h05, 8'h07, 1'b0, 1'b1);  // FE, c0, v0
        run_op(8, 8'h80, 8'h01, 1'b0, 1'b1);  // 7F, c1, v1
        run_op(8, 8'h10, 8'h20, 1'b1, 1'b1);  // cin ignored on subtract

        // start held high, operands scrambled while busy
        @(negedge clk);
        a = va[0]; b = vb[0]; cin = 1'b0; sub = 1'b0; st8 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            q.push_back(model(8, a, b, cin, sub));
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("hold_sum", 32'(obs(8)), 32'(last_exp));
                chk("hold_busy", 32'({done8, busy8}), 32'd1);
                a = 8'($urandom); b = 8'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            @(negedge clk);
            chk("hold_done", 32'(done8), 32'd1);
            e = q.pop_front();
            chk("hold_res", 32'(obs(8)), 32'(e));
            last_exp = e;
            if (j < 2) begin
                a = va[j+1]; b = vb[j+1]; cin = (j == 1); sub = (j == 0);
            end else begin
                st8 = 1'b0;
            end
        end
        @(negedge clk);
        chk("hold_end_done", 32'(done8), 32'd0);

        // Reset three cycles into RUN
        @(negedge clk);
        a = 8'h55; b = 8'h0F; cin = 1'b0; sub = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_out", 32'(obs(8)), 32'd0);
        chk("rst_mid_ctl", 32'({done8, busy8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'({done8, busy8}), 32'd0);
        end
        run_op(8, 8'h12, 8'h34, 1'b0, 1'b0);  // 46

        // Exhaustive WIDTH=4 and WIDTH=1
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++)
                        run_op(4, 8'(x), 8'(y), 1'(c), 1'(s));
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++)
                        run_op(1, 8'(x), 8'(y), 1'(c), 1'(s));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
